// File: rtl/control_unit_if.sv
// Decode-stage bus between fetch/decode and the main control unit.
// Optional debug field dec_onehot exists only when CU_ONEHOT_DEBUG_EN is defined.
interface control_unit_if;
  logic [2:0] opcode;
  logic       stall;
  logic       flush;
  logic       RegDst;
  logic       Branch;
  logic       MemRead;
  logic       MemToReg;
  logic [1:0] ALUop;
  logic       MemWrite;
  logic       ALUSrc;
  logic       RegWrite;
  logic [1:0] PCSrc;
  logic       ExtSel;
`ifdef CU_ONEHOT_DEBUG_EN
  logic [7:0] dec_onehot;
`endif

  // Upstream side: supplies the opcode and pipeline controls, observes control word.
  modport master (
    output opcode, stall, flush,
    input  RegDst, Branch, MemRead, MemToReg, ALUop, MemWrite, ALUSrc,
           RegWrite, PCSrc, ExtSel
`ifdef CU_ONEHOT_DEBUG_EN
    , input dec_onehot
`endif
  );

  // Control unit side.
  modport slave (
    input  opcode, stall, flush,
    output RegDst, Branch, MemRead, MemToReg, ALUop, MemWrite, ALUSrc,
           RegWrite, PCSrc, ExtSel
`ifdef CU_ONEHOT_DEBUG_EN
    , output dec_onehot
`endif
  );
endinterface

// File: rtl/control_unit.sv
// Main decoder for the 16-bit single-issue ISA. The 3-bit opcode is decoded
// combinationally and captured in a register bank, so outputs appear one cycle
// after the opcode is sampled. Edge priority: reset > flush > stall > decode.
// Optional macro CU_ONEHOT_DEBUG_EN adds a registered one-hot opcode output.
module control_unit (
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.slave  bus
);

  // Packed control word, MSB first:
  // RegDst Branch MemRead MemToReg ALUop[1:0] MemWrite ALUSrc RegWrite PCSrc[1:0] ExtSel
  localparam int CW = 12;
  localparam logic [CW-1:0] NOP_WORD = '0;

  logic [CW-1:0] w_ctrl_word;
  logic [CW-1:0] r_ctrl_word;

  // Decode table; every opcode is defined so no X can leak out.
  always_comb begin
    w_ctrl_word = NOP_WORD;
    case (bus.opcode)
      3'b000:  w_ctrl_word = 12'b1_0_0_0_10_0_0_1_00_0; // R-type
      3'b001:  w_ctrl_word = 12'b0_0_0_0_00_0_1_1_00_1; // ADDI
      3'b010:  w_ctrl_word = 12'b0_0_0_0_11_0_1_1_00_0; // ORI
      3'b011:  w_ctrl_word = 12'b0_0_1_1_00_0_1_1_00_1; // LW
      3'b100:  w_ctrl_word = 12'b0_0_0_0_00_1_1_0_00_1; // SW
      3'b101:  w_ctrl_word = 12'b0_1_0_0_01_0_0_0_01_1; // BEQ
      3'b110:  w_ctrl_word = 12'b0_0_0_0_00_0_0_0_10_0; // J
      3'b111:  w_ctrl_word = 12'b0_0_0_0_00_0_0_0_11_0; // JR
      default: w_ctrl_word = NOP_WORD;
    endcase
  end

  // Decode pipeline register: reset/flush load NOP, stall holds, else capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl_word <= NOP_WORD;
    end else if (bus.flush) begin
      r_ctrl_word <= NOP_WORD;
    end else if (!bus.stall) begin
      r_ctrl_word <= w_ctrl_word;
    end
  end

  assign bus.RegDst   = r_ctrl_word[11];
  assign bus.Branch   = r_ctrl_word[10];
  assign bus.MemRead  = r_ctrl_word[9];
  assign bus.MemToReg = r_ctrl_word[8];
  assign bus.ALUop    = r_ctrl_word[7:6];
  assign bus.MemWrite = r_ctrl_word[5];
  assign bus.ALUSrc   = r_ctrl_word[4];
  assign bus.RegWrite = r_ctrl_word[3];
  assign bus.PCSrc    = r_ctrl_word[2:1];
  assign bus.ExtSel   = r_ctrl_word[0];

`ifdef CU_ONEHOT_DEBUG_EN
  logic [7:0] w_onehot;
  logic [7:0] r_onehot;

  // One-hot of the opcode being decoded.
  always_comb begin
    w_onehot = 8'b0000_0001 << bus.opcode;
  end

  // Debug register shares the control word's reset/flush/stall behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_onehot <= 8'b0000_0000;
    end else if (bus.flush) begin
      r_onehot <= 8'b0000_0000;
    end else if (!bus.stall) begin
      r_onehot <= w_onehot;
    end
  end

  assign bus.dec_onehot = r_onehot;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with hand-computed control words.
// Builds with or without CU_ONEHOT_DEBUG_EN.
module tb_control_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  control_unit_if cu_bus ();

  control_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written expected words, MSB first:
  // RegDst Branch MemRead MemToReg ALUop MemWrite ALUSrc RegWrite PCSrc ExtSel
  logic [11:0] exp_tbl [8];
  logic [7:0]  exp_oh  [8];

  initial begin
    exp_tbl[0] = 12'h888; // R-type
    exp_tbl[1] = 12'h019; // ADDI
    exp_tbl[2] = 12'h0D8; // ORI
    exp_tbl[3] = 12'h319; // LW
    exp_tbl[4] = 12'h031; // SW
    exp_tbl[5] = 12'h443; // BEQ
    exp_tbl[6] = 12'h004; // J
    exp_tbl[7] = 12'h006; // JR
    exp_oh[0] = 8'h01; exp_oh[1] = 8'h02; exp_oh[2] = 8'h04; exp_oh[3] = 8'h08;
    exp_oh[4] = 8'h10; exp_oh[5] = 8'h20; exp_oh[6] = 8'h40; exp_oh[7] = 8'h80;
  end

  function automatic logic [11:0] obs_word();
    return {cu_bus.RegDst, cu_bus.Branch, cu_bus.MemRead, cu_bus.MemToReg,
            cu_bus.ALUop, cu_bus.MemWrite, cu_bus.ALUSrc, cu_bus.RegWrite,
            cu_bus.PCSrc, cu_bus.ExtSel};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic rn, input logic [2:0] op, input logic st, input logic fl);
    @(negedge clk);
    rst_n         = rn;
    cu_bus.opcode = op;
    cu_bus.stall  = st;
    cu_bus.flush  = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [11:0] exp);
    check_eq(tag, {20'd0, obs_word()}, {20'd0, exp});
    check_eq({tag, "_memrw_excl"}, {31'd0, cu_bus.MemRead & cu_bus.MemWrite}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    cu_bus.opcode = 3'b000;
    cu_bus.stall  = 1'b0;
    cu_bus.flush  = 1'b0;

    // Reset held for two edges.
    cycle(1'b0, 3'b000, 1'b0, 1'b0);
    cycle(1'b0, 3'b000, 1'b0, 1'b0);
    check_word("reset", 12'h000);
`ifdef CU_ONEHOT_DEBUG_EN
    check_eq("reset_onehot", {24'd0, cu_bus.dec_onehot}, 32'd0);
`endif

    // First decode after release.
    cycle(1'b1, 3'b000, 1'b0, 1'b0);
    check_word("post_reset_rtype", 12'h888);

    // Sweep all opcodes.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 3'(i), 1'b0, 1'b0);
      check_word($sformatf("sweep_op%0d", i), exp_tbl[i]);
`ifdef CU_ONEHOT_DEBUG_EN
      check_eq($sformatf("sweep_onehot%0d", i), {24'd0, cu_bus.dec_onehot}, {24'd0, exp_oh[i]});
`endif
    end

    // Stall holds BEQ while SW is presented.
    cycle(1'b1, 3'b101, 1'b0, 1'b0);
    check_word("load_beq", 12'h443);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'b100, 1'b1, 1'b0);
      check_word($sformatf("stall_hold%0d", i), 12'h443);
`ifdef CU_ONEHOT_DEBUG_EN
      check_eq($sformatf("stall_onehot%0d", i), {24'd0, cu_bus.dec_onehot}, 32'h20);
`endif
    end
    cycle(1'b1, 3'b100, 1'b0, 1'b0);
    check_word("stall_release_sw", 12'h031);

    // Flush beats stall.
    cycle(1'b1, 3'b110, 1'b0, 1'b0);
    check_word("load_j", 12'h004);
    cycle(1'b1, 3'b111, 1'b1, 1'b1);
    check_word("flush_over_stall", 12'h000);
`ifdef CU_ONEHOT_DEBUG_EN
    check_eq("flush_onehot", {24'd0, cu_bus.dec_onehot}, 32'd0);
`endif
    // Stall right after flush keeps NOP.
    cycle(1'b1, 3'b001, 1'b1, 1'b0);
    check_word("stall_after_flush", 12'h000);

    // Reset during stall, then normal decode.
    cycle(1'b1, 3'b011, 1'b0, 1'b0);
    check_word("load_lw", 12'h319);
    cycle(1'b0, 3'b011, 1'b1, 1'b0);
    check_word("reset_mid_stall", 12'h000);
    cycle(1'b1, 3'b010, 1'b0, 1'b0);
    check_word("post_reset_ori", 12'h0D8);
    cycle(1'b1, 3'b111, 1'b0, 1'b0);
    check_word("final_jr", 12'h006);
`ifdef CU_ONEHOT_DEBUG_EN
    check_eq("jr_onehot", {24'd0, cu_bus.dec_onehot}, 32'h80);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
